// File: rtl/store_write_buffer.sv
// Posted-store FIFO between the CPU memory stage and the 1024-word data memory.
// Stores drain in program order one per cycle. Loads can take data forwarded
// from the youngest pending store to the same word address.
module store_write_buffer #(
  parameter int DEPTH = 4,
  parameter int PTRW  = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            st_valid,
  input  logic [31:0]     st_addr,
  input  logic [31:0]     st_data,
  input  logic [31:0]     st_pc,
  output logic            st_ready,
  input  logic [31:0]     ld_addr,
  output logic            ld_hit,
  output logic [31:0]     ld_data,
  input  logic            mem_busy,
  output logic            mem_we,
  output logic [31:0]     mem_addr,
  output logic [31:0]     mem_wd,
  output logic [31:0]     mem_pc,
  output logic [PTRW:0]   count,
  output logic            empty
);

  logic [31:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      pc_q   [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PTRW-1:0]  head;
  logic [PTRW-1:0]  tail;
  logic [PTRW:0]    count_q;
  logic             full;
  logic             enq;
  logic             deq;
  logic [PTRW-1:0]  fwd_idx;

  assign full     = (count_q == (PTRW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign st_ready = !full;
  assign enq      = st_valid && st_ready;
  assign mem_we   = !empty && !mem_busy;
  assign deq      = mem_we;
  assign count    = count_q;

  // Head entry drives the memory write port; zeros while nothing is pending
  always_comb begin
    mem_addr = '0;
    mem_wd   = '0;
    mem_pc   = '0;
    if (!empty) begin
      mem_addr = addr_q[head];
      mem_wd   = data_q[head];
      mem_pc   = pc_q[head];
    end
  end

  // Walk entries oldest to youngest so the last match seen is the youngest
  always_comb begin
    ld_hit  = 1'b0;
    ld_data = '0;
    fwd_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head + PTRW'(i);
      if (valid_q[fwd_idx] && (addr_q[fwd_idx][11:2] == ld_addr[11:2])) begin
        ld_hit  = 1'b1;
        ld_data = data_q[fwd_idx];
      end
    end
  end

  // Control state: pointers, occupancy and valid bits; reset drops all pending stores
  always_ff @(posedge clk) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (deq) begin
        valid_q[head] <= 1'b0;
        head          <= head + 1'b1;
      end
      if (enq) begin
        valid_q[tail] <= 1'b1;
        tail          <= tail + 1'b1;
      end
      if (enq && !deq) begin
        count_q <= count_q + 1'b1;
      end else if (deq && !enq) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Entry payload storage; only meaningful while the matching valid bit is set
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail] <= st_addr;
      data_q[tail] <= st_data;
      pc_q[tail]   <= st_pc;
    end
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed self-checking bench for store_write_buffer.
module tb_store_write_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [31:0] st_pc;
  logic        st_ready;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        mem_busy;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_pc;
  logic [2:0]  count;
  logic        empty;

  int total = 0;
  int bad   = 0;

  store_write_buffer #(.DEPTH(4), .PTRW(2)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_pc(st_pc),
    .st_ready(st_ready),
    .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
    .mem_busy(mem_busy), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_pc(mem_pc),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one store for a single edge
  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
    st_valid = 1'b1; st_addr = a; st_data = d; st_pc = p;
    tick();
    st_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_pc = '0;
    ld_addr = 32'h10; mem_busy = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    total++; if (st_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_ready got=%b exp=1", st_ready); end
    total++; if (empty !== 1'b1) begin bad++; $display("[TB] FAIL rst_empty got=%b exp=1", empty); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("[TB] FAIL rst_we got=%b exp=0", mem_we); end
    total++; if (ld_hit !== 1'b0 || ld_data !== 32'h0) begin bad++; $display("[TB] FAIL rst_ld got=%b/%h exp=0/0", ld_hit, ld_data); end
    total++; if (count !== 3'd0) begin bad++; $display("[TB] FAIL rst_count got=%0d exp=0", count); end
    total++; if (mem_addr !== 32'h0 || mem_wd !== 32'h0 || mem_pc !== 32'h0) begin bad++; $display("[TB] FAIL rst_mem got=%h/%h/%h exp=0", mem_addr, mem_wd, mem_pc); end
  endtask

  task automatic test_forwarding();
    mem_busy = 1'b1;
    push(32'h10, 32'h11111111, 32'h100);
    push(32'h20, 32'h22222222, 32'h104);
    push(32'h10, 32'h33333333, 32'h108);
    total++; if (count !== 3'd3) begin bad++; $display("[TB] FAIL fwd_count got=%0d exp=3", count); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("[TB] FAIL fwd_busy_we got=%b exp=0", mem_we); end
    ld_addr = 32'h10; #1;
    total++; if (ld_hit !== 1'b1 || ld_data !== 32'h33333333) begin bad++; $display("[TB] FAIL fwd_youngest got=%b/%h exp=1/33333333", ld_hit, ld_data); end
    ld_addr = 32'h20; #1;
    total++; if (ld_hit !== 1'b1 || ld_data !== 32'h22222222) begin bad++; $display("[TB] FAIL fwd_b got=%b/%h exp=1/22222222", ld_hit, ld_data); end
    ld_addr = 32'h30; #1;
    total++; if (ld_hit !== 1'b0 || ld_data !== 32'h0) begin bad++; $display("[TB] FAIL fwd_miss got=%b/%h exp=0/0", ld_hit, ld_data); end
  endtask

  task automatic test_full();
    push(32'h50, 32'h44444444, 32'h10C);
    total++; if (count !== 3'd4) begin bad++; $display("[TB] FAIL full_count got=%0d exp=4", count); end
    total++; if (st_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_ready got=%b exp=0", st_ready); end
    push(32'h60, 32'h55555555, 32'h110);
    total++; if (count !== 3'd4) begin bad++; $display("[TB] FAIL full_ignore got=%0d exp=4", count); end
    ld_addr = 32'h60; #1;
    total++; if (ld_hit !== 1'b0) begin bad++; $display("[TB] FAIL full_nowrite got=%b exp=0", ld_hit); end
  endtask

  task automatic test_drain();
    logic [31:0] ea [4];
    logic [31:0] ed [4];
    logic [31:0] ep [4];
    ea = '{32'h10, 32'h20, 32'h10, 32'h50};
    ed = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    ep = '{32'h100, 32'h104, 32'h108, 32'h10C};
    mem_busy = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      total++; if (mem_we !== 1'b1 || mem_addr !== ea[i] || mem_wd !== ed[i] || mem_pc !== ep[i]) begin
        bad++; $display("[TB] FAIL drain%0d got=%b/%h/%h/%h exp=1/%h/%h/%h", i, mem_we, mem_addr, mem_wd, mem_pc, ea[i], ed[i], ep[i]);
      end
      tick();
    end
    total++; if (empty !== 1'b1 || mem_we !== 1'b0) begin bad++; $display("[TB] FAIL drain_end got=%b/%b exp=1/0", empty, mem_we); end
  endtask

  task automatic test_back_to_back();
    mem_busy = 1'b1;
    push(32'h200, 32'hD000, 32'h400);
    push(32'h204, 32'hD001, 32'h404);
    mem_busy = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c < 6) begin
        st_valid = 1'b1;
        st_addr  = 32'h200 + 32'(4 * (c + 2));
        st_data  = 32'hD000 + 32'(c + 2);
        st_pc    = 32'h400 + 32'(4 * (c + 2));
      end else begin
        st_valid = 1'b0;
      end
      #1;
      total++; if (mem_we !== 1'b1 || mem_addr !== 32'h200 + 32'(4 * c) || mem_wd !== 32'hD000 + 32'(c) || mem_pc !== 32'h400 + 32'(4 * c)) begin
        bad++; $display("[TB] FAIL b2b_order%0d got=%b/%h/%h/%h", c, mem_we, mem_addr, mem_wd, mem_pc);
      end
      if (c < 6) begin
        total++; if (count !== 3'd2) begin bad++; $display("[TB] FAIL b2b_count%0d got=%0d exp=2", c, count); end
      end
      tick();
    end
    st_valid = 1'b0; #1;
    total++; if (empty !== 1'b1) begin bad++; $display("[TB] FAIL b2b_empty got=%b exp=1", empty); end
  endtask

  task automatic test_same_cycle_visibility();
    mem_busy = 1'b1;
    ld_addr = 32'h40;
    st_valid = 1'b1; st_addr = 32'h40; st_data = 32'hCAFE0040; st_pc = 32'h500;
    #1;
    total++; if (ld_hit !== 1'b0) begin bad++; $display("[TB] FAIL vis_same got=%b exp=0", ld_hit); end
    tick();
    st_valid = 1'b0; #1;
    total++; if (ld_hit !== 1'b1 || ld_data !== 32'hCAFE0040) begin bad++; $display("[TB] FAIL vis_next got=%b/%h exp=1/cafe0040", ld_hit, ld_data); end
    ld_addr = 32'h43; #1;
    total++; if (ld_hit !== 1'b1 || ld_data !== 32'hCAFE0040) begin bad++; $display("[TB] FAIL vis_bytes got=%b/%h exp=1/cafe0040", ld_hit, ld_data); end
    ld_addr = 32'h1040; #1;
    total++; if (ld_hit !== 1'b1) begin bad++; $display("[TB] FAIL vis_hibits got=%b exp=1", ld_hit); end
    mem_busy = 1'b0; #1;
    total++; if (mem_we !== 1'b1 || ld_hit !== 1'b1) begin bad++; $display("[TB] FAIL vis_draining got=%b/%b exp=1/1", mem_we, ld_hit); end
    tick();
    total++; if (empty !== 1'b1 || ld_hit !== 1'b0) begin bad++; $display("[TB] FAIL vis_drained got=%b/%b exp=1/0", empty, ld_hit); end
  endtask

  task automatic test_reset_mid_drain();
    mem_busy = 1'b1;
    push(32'h70, 32'h77770000, 32'h600);
    push(32'h74, 32'h77770001, 32'h604);
    push(32'h78, 32'h77770002, 32'h608);
    mem_busy = 1'b0; #1;
    total++; if (mem_we !== 1'b1 || mem_addr !== 32'h70) begin bad++; $display("[TB] FAIL mid_first got=%b/%h exp=1/70", mem_we, mem_addr); end
    tick();
    total++; if (count !== 3'd2) begin bad++; $display("[TB] FAIL mid_count got=%0d exp=2", count); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ld_addr = 32'h78; #1;
    total++; if (count !== 3'd0 || empty !== 1'b1) begin bad++; $display("[TB] FAIL mid_rst got=%0d/%b exp=0/1", count, empty); end
    total++; if (ld_hit !== 1'b0 || ld_data !== 32'h0) begin bad++; $display("[TB] FAIL mid_ld got=%b/%h exp=0/0", ld_hit, ld_data); end
    for (int i = 0; i < 3; i++) begin
      total++; if (mem_we !== 1'b0) begin bad++; $display("[TB] FAIL mid_nowrite%0d got=%b exp=0", i, mem_we); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_full();
    test_drain();
    test_back_to_back();
    test_same_cycle_visibility();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
- Word-granular posted-store FIFO between the CPU memory stage and the 1024-word data memory.
- Accepts stores from the core and drains them one per cycle to the memory write port, in program order.
- Forwards the youngest buffered value to loads whose word address matches a pending store.
- Carries the store PC alongside each entry so the memory's write trace stays attributable.

Parameters:
- DEPTH, 4, number of entries; power of two, >=2
- PTRW, 2, pointer width = log2(DEPTH)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- st_valid  in  1  core presents a store this cycle
- st_addr  in  32  store byte address
- st_data  in  32  store word
- st_pc  in  32  PC of the store instruction
- st_ready  out  1  buffer can accept (= !full)
- ld_addr  in  32  load byte address (combinational lookup)
- ld_hit  out  1  some pending entry matches ld_addr[11:2]
- ld_data  out  32  data of youngest matching entry; 0 when !ld_hit
- mem_busy  in  1  memory port unavailable this cycle; hold drain
- mem_we  out  1  write strobe to data memory
- mem_addr  out  32  head entry address
- mem_wd  out  32  head entry data
- mem_pc  out  32  head entry PC
- count  out  PTRW+1  number of valid entries
- empty  out  1  count==0

Behaviour:
- One clock `clk`; reset is synchronous and active-high (`reset`). All state updates on rising clk.
- Storage: circular array of DEPTH entries {addr[31:0], data[31:0], pc[31:0], valid}, plus head, tail and count registers.
- Reset, synchronous and active-high, takes priority over everything:
  - head=tail=0, count=0, all valid=0; pending stores are discarded even if mid-drain.
  - Following edge outputs: st_ready=1, empty=1, mem_we=0, ld_hit=0, ld_data=0.
  - mem_addr/mem_wd/mem_pc=0 while empty.
- Enqueue (enq = st_valid && st_ready):
  - Writes the tail entry and sets its valid bit; tail wraps DEPTH-1 -> 0.
  - st_valid while full is ignored; nothing changes.
- Drain (deq = mem_we):
  - mem_we = !empty && !mem_busy, combinational.
  - mem_addr/mem_wd/mem_pc are driven from the head entry; 0 when empty.
  - On the edge where mem_we=1, memory captures the word, head clears valid and advances (wraps).
- Count:
  - enq && !deq -> +1
  - deq && !enq -> -1
  - both -> unchanged; a simultaneous enq/deq at count=DEPTH cannot occur since st_ready=0.
- Latency: a store accepted at edge N reaches mem_we=1 in the cycle after edge N at the earliest. There is no empty-bypass.
- Forwarding:
  - Compare ld_addr[11:2] against addr[11:2] of every valid entry.
  - ld_hit=1 if any match; ld_data = data of the match closest to the tail (youngest).
  - An entry being drained in the current cycle still counts; memory updates only at the edge.
  - A store presented on st_* in the same cycle is NOT visible to ld_* that cycle.
  - The core selects ld_hit ? ld_data : memory read.
- Address bits [1:0] and [31:12] are stored and passed through unchanged but ignored for matching.
- Ordering is strict FIFO. No coalescing: two stores to one address occupy two entries and both drain.
- No X on any output after the first reset edge.

Test Plan:
- reset=1 one edge, then mem_busy=1, three stores (A=0x10/0x11111111, B=0x20/0x22222222, C=0x10/0x33333333) -> count=3, mem_we=0, ld_addr=0x10 gives ld_hit=1, ld_data=0x33333333 (youngest); ld_addr=0x30 gives ld_hit=0, ld_data=0.
- Continue from previous, add a 4th store -> count=4, st_ready=0; a 5th st_valid is ignored, count stays 4, tail unchanged.
- Drop mem_busy -> mem_we=1 for four consecutive cycles with mem_addr 0x10, 0x20, 0x10, then the 4th, in order; mem_pc matches the issuing PCs; then empty=1, mem_we=0.
- count=2, mem_busy=0, st_valid=1 for several cycles -> count holds at 2, and drained order equals accepted order across the pointer wrap.
- Store to 0x40 while ld_addr=0x40 in the same cycle -> ld_hit=0; next cycle ld_hit=1. Also ld_addr=0x43 matches the 0x40 entry.
- Mid-drain with 3 entries, assert reset one edge -> count=0, empty=1, mem_we=0, ld_hit=0; no further memory writes.
